// File: rtl/stump_step_controller.sv
// stump_step_controller: host-driven STEP / RUN / DUTRESET sequencer that synthesises a slow DUT clock from clk.
// Breakpoint comparator is compiled in only when STUMP_STEP_BREAKPOINT_EN is defined.
module stump_step_controller (
  input  logic        clk,
  input  logic        reset,
  input  logic        cmd_valid,
  input  logic [1:0]  cmd_op,
  input  logic [15:0] cmd_count,
  output logic        cmd_ready,
  input  logic        bp_en,
  input  logic [15:0] bp_addr,
  input  logic        dut_fetch,
  input  logic [15:0] dut_addr,
  output logic        dut_clk,
  output logic        dut_reset,
  output logic        busy,
  output logic        bp_hit,
  output logic [31:0] cycle_count
);

  // Handshake: a command transfers on the clk edge where cmd_valid && cmd_ready are both high;
  // while busy only STOP is ready, so any other command simply waits with cmd_valid held.
  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    CLK_HI = 2'd1,
    CLK_LO = 2'd2,
    RST_HI = 2'd3
  } state_t;

  localparam logic [1:0] OP_STOP     = 2'b00;
  localparam logic [1:0] OP_STEP     = 2'b01;
  localparam logic [1:0] OP_RUN      = 2'b10;
  localparam logic [1:0] OP_DUTRESET = 2'b11;

  state_t      state;
  state_t      state_nxt;
  logic [15:0] remaining;
  logic [15:0] remaining_nxt;
  logic        run_mode;
  logic        run_mode_nxt;
  logic        stop_pending;
  logic        stop_pending_nxt;
  logic        bp_hit_q;
  logic        bp_hit_nxt;
  logic [31:0] cycle_count_nxt;
  logic        bp_match;
  logic        accept;
  logic        cmd_stop;
  logic        halt;

  assign cmd_ready = (state == IDLE) || (cmd_op == OP_STOP);
  assign accept    = cmd_valid && cmd_ready;
  assign cmd_stop  = accept && (cmd_op == OP_STOP);
  assign busy      = (state != IDLE);

`ifdef STUMP_STEP_BREAKPOINT_EN
  assign bp_match = bp_en && dut_fetch && (dut_addr == bp_addr);

  always_ff @(posedge clk) begin
    if (reset) begin
      bp_hit_q <= 1'b0;
    end else begin
      bp_hit_q <= bp_hit_nxt;
    end
  end

  assign bp_hit = bp_hit_q;
`else
  logic unused_bp;
  assign bp_match  = 1'b0;
  assign bp_hit_q  = 1'b0;
  assign bp_hit    = 1'b0;
  assign unused_bp = ^{bp_en, bp_addr, dut_fetch, dut_addr, bp_hit_nxt};
`endif

  always_comb begin
    state_nxt        = state;
    remaining_nxt    = remaining;
    run_mode_nxt     = run_mode;
    stop_pending_nxt = stop_pending;
    bp_hit_nxt       = bp_hit_q;
    cycle_count_nxt  = cycle_count;
    halt             = 1'b0;
    case (state)
      IDLE: begin
        if (accept) begin
          case (cmd_op)
            OP_STEP: begin
              bp_hit_nxt = 1'b0;
              if (cmd_count != 16'd0) begin
                state_nxt       = CLK_HI;
                run_mode_nxt    = 1'b0;
                remaining_nxt   = cmd_count - 16'd1;
                cycle_count_nxt = cycle_count + 32'd1;
              end
            end
            OP_RUN: begin
              bp_hit_nxt      = 1'b0;
              state_nxt       = CLK_HI;
              run_mode_nxt    = 1'b1;
              remaining_nxt   = 16'd0;
              cycle_count_nxt = cycle_count + 32'd1;
            end
            OP_DUTRESET: begin
              state_nxt       = RST_HI;
              cycle_count_nxt = 32'd0;
            end
            default: begin
            end
          endcase
        end
      end
      CLK_HI: begin
        state_nxt = CLK_LO;
        if (cmd_stop) begin
          stop_pending_nxt = 1'b1;
        end
      end
      CLK_LO: begin
        // dut_reset still high here means this is the low half of a DUT reset pulse.
        if (dut_reset) begin
          state_nxt = IDLE;
        end else begin
          halt = bp_match || stop_pending || cmd_stop || (!run_mode && (remaining == 16'd0));
          if (bp_match) begin
            bp_hit_nxt = 1'b1;
          end
          if (halt) begin
            state_nxt        = IDLE;
            stop_pending_nxt = 1'b0;
          end else begin
            state_nxt       = CLK_HI;
            cycle_count_nxt = cycle_count + 32'd1;
            if (!run_mode) begin
              remaining_nxt = remaining - 16'd1;
            end
          end
        end
      end
      RST_HI: begin
        state_nxt = CLK_LO;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state        <= IDLE;
      remaining    <= 16'd0;
      run_mode     <= 1'b0;
      stop_pending <= 1'b0;
      cycle_count  <= 32'd0;
      dut_clk      <= 1'b0;
      dut_reset    <= 1'b0;
    end else begin
      state        <= state_nxt;
      remaining    <= remaining_nxt;
      run_mode     <= run_mode_nxt;
      stop_pending <= stop_pending_nxt;
      cycle_count  <= cycle_count_nxt;
      dut_clk      <= (state_nxt == CLK_HI) || (state_nxt == RST_HI);
      dut_reset    <= (state_nxt == RST_HI) || (state == RST_HI);
    end
  end

endmodule
